// File: rtl/ssd_display_driver_if.sv
// -----------------------------------------------------------------------------
// ssd_display_driver_if
//
// Bundles the display driver's data and display signals so the producer of
// the debug value and the driver connect through one port.
//
//   value    master -> slave  13-bit unsigned value to display (0..8191)
//   busy     slave -> master  conversion in progress
//   bcd      slave -> master  last completed conversion, four BCD digits
//   Anode    slave -> master  active-low digit enables, [0] = leftmost digit
//   LED_out  slave -> master  active-low segments, [0] = a ... [6] = g
// -----------------------------------------------------------------------------
interface ssd_display_driver_if;
    logic [12:0] value;
    logic        busy;
    logic [15:0] bcd;
    logic [0:3]  Anode;
    logic [0:6]  LED_out;

    // The side that supplies the value to display.
    modport master (
        output value,
        input  busy,
        input  bcd,
        input  Anode,
        input  LED_out
    );

    // The display driver itself.
    modport slave (
        input  value,
        output busy,
        output bcd,
        output Anode,
        output LED_out
    );
endinterface

// File: rtl/ssd_display_driver.sv
// -----------------------------------------------------------------------------
// ssd_display_driver
//
// Converts a 13-bit binary value into four BCD digits with a sequential
// double-dabble converter, then time-multiplexes the digits onto a 4-anode,
// 7-segment display from a refresh-tick counter on the single system clock.
//
// Parameters
//   REFRESH_DIV    system-clock cycles per digit slot (>= 2)
//   BLANK_LEADING  1 = blank leading zero digits (units digit always shown)
//
// Ports
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   dbg   ssd_display_driver_if.slave: value in; busy, bcd, Anode, LED_out out
// -----------------------------------------------------------------------------
module ssd_display_driver #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    ssd_display_driver_if.slave  dbg
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Thirteen shift/adjust iterations for a 13-bit input.
    localparam logic [3:0] LAST_ITER = 4'd12;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Double-dabble adjust: a nibble of 5 or more would become >= 10 after
    // the shift, so add 3 first to carry into the next decimal digit.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Active-low segment code, leftmost bit is segment a.
    function automatic logic [0:6] seg(input logic [3:0] digit);
        logic [0:6] code;
        case (digit)
            4'd0:    code = 7'b0000001;
            4'd1:    code = 7'b1001111;
            4'd2:    code = 7'b0010010;
            4'd3:    code = 7'b0000110;
            4'd4:    code = 7'b1001100;
            4'd5:    code = 7'b0100100;
            4'd6:    code = 7'b0100000;
            4'd7:    code = 7'b0001111;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0000100;
            default: code = SEG_BLANK; // non-decimal nibble: show nothing
        endcase
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // Converter state
    // -------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [12:0] cap_q,   cap_d;    // value the running/last conversion used
    logic [28:0] sh_q,    sh_d;     // {thousands, hundreds, tens, units, bin}
    logic [3:0]  iter_q,  iter_d;
    logic [15:0] bcd_q,   bcd_d;

    logic [28:0] sh_adj;

    // Adjust every BCD nibble of the shift register before the next shift.
    always_comb begin
        sh_adj          = sh_q;
        sh_adj[28:25]   = add3(sh_q[28:25]);
        sh_adj[24:21]   = add3(sh_q[24:21]);
        sh_adj[20:17]   = add3(sh_q[20:17]);
        sh_adj[16:13]   = add3(sh_q[16:13]);
    end

    // NOTE: every signal gets its default at the top of a combinational
    // block so that no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        sh_d    = sh_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;

        case (state_q)
            IDLE: begin
                // Only a change relative to the last captured value starts
                // work, so a steady input costs nothing and value=0 after
                // reset leaves bcd at zero.
                if (dbg.value != cap_q) begin
                    cap_d   = dbg.value;
                    sh_d    = {16'b0, dbg.value};
                    iter_d  = 4'd0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                sh_d   = {sh_adj[27:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Publish all four digits in one edge so the display never
                // sees a half-converted number.
                bcd_d   = sh_q[28:13];
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Refresh / digit multiplexing
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       idx_q,   idx_d;
    logic [0:3]       anode_q, anode_d;
    logic [0:6]       led_q,   led_d;

    logic       tick;
    logic [3:0] digit_sel;
    logic       blank_sel;
    logic [2:0] lead_zero;   // [k]: digit k and all digits left of it are 0

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        lead_zero[0] = (bcd_q[15:12] == 4'd0);
        lead_zero[1] = lead_zero[0] && (bcd_q[11:8] == 4'd0);
        lead_zero[2] = lead_zero[1] && (bcd_q[7:4]  == 4'd0);
    end

    // idx 0 is the leftmost (thousands) digit, idx 3 the units digit.
    always_comb begin
        digit_sel = bcd_q[3:0];
        blank_sel = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_sel = bcd_q[15:12];
                blank_sel = BLANK_LEADING && lead_zero[0];
            end
            2'd1: begin
                digit_sel = bcd_q[11:8];
                blank_sel = BLANK_LEADING && lead_zero[1];
            end
            2'd2: begin
                digit_sel = bcd_q[7:4];
                blank_sel = BLANK_LEADING && lead_zero[2];
            end
            default: begin
                // Units digit is always shown, even when zero.
                digit_sel = bcd_q[3:0];
                blank_sel = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        anode_d = anode_q;
        led_d   = led_q;

        if (tick) begin
            cnt_d          = '0;
            anode_d        = 4'b1111;
            anode_d[idx_q] = 1'b0;      // blanked digits still get an anode
            led_d          = blank_sel ? SEG_BLANK : seg(digit_sel);
            idx_d          = idx_q + 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= '0;
            sh_q    <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            anode_q <= 4'b1111;
            led_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            sh_q    <= sh_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            led_q   <= led_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dbg.busy    = (state_q != IDLE);
    assign dbg.bcd     = bcd_q;
    assign dbg.Anode   = anode_q;
    assign dbg.LED_out = led_q;

endmodule
